// File: rtl/xsimbus_responder_if.sv
// Simulation-bus signal bundle between the arbiter (master side) and a
// device responder (slave side).
interface xsimbus_responder_if #(
    parameter int ADDR_W = 8
);
    logic              hold_in;
    logic [4:0]        sel_id_in;
    logic [ADDR_W-1:0] addr_in;
    logic              rw_in;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              ready_out;
    logic              err_out;
    logic              busy_out;

    modport master (
        output hold_in, sel_id_in, addr_in, rw_in, data_in,
        input  data_out, ready_out, err_out, busy_out
    );

    modport slave (
        input  hold_in, sel_id_in, addr_in, rw_in, data_in,
        output data_out, ready_out, err_out, busy_out
    );
endinterface

// File: rtl/xsimbus_responder.sv
// Device-side responder for the simulation bus. Claims transactions whose
// selected ID matches DEV_ID, waits WAIT_CYCLES, then services them from an
// internal byte RAM and pulses ready (and err for out-of-range addresses).
module xsimbus_responder #(
    parameter logic [4:0] DEV_ID      = 5'd1,
    parameter int         ADDR_W      = 8,
    parameter int         DEPTH       = 256,
    parameter int         WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    xsimbus_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable; the compare stays
    // unsigned and never wraps.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              armed;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [7:0]        data_q;
    logic [7:0]        data_r;
    logic              ready_r;
    logic              err_r;
    logic              busy_r;
    logic [7:0]        mem [DEPTH];

    logic              deselect;
    logic              req;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // A still-held request is not re-accepted until the bus has deselected us.
    assign deselect = !bus.hold_in || (bus.sel_id_in != DEV_ID);
    assign req      = !deselect && armed;
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign idx      = addr_q[IDX_W-1:0];

    assign bus.data_out  = data_r;
    assign bus.ready_out = ready_r;
    assign bus.err_out   = err_r;
    assign bus.busy_out  = busy_r;

    // Request FSM: accept, count wait states, complete with a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            armed   <= 1'b1;
            data_r  <= 8'h00;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            if (deselect) begin
                armed <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q <= bus.addr_in;
                        rw_q   <= bus.rw_in;
                        data_q <= bus.data_in;
                        cnt    <= WAIT_L;
                        armed  <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= (WAIT_L != 4'd0) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_r <= 1'b1;
                    err_r   <= !in_range;
                    busy_r  <= 1'b0;
                    state   <= S_IDLE;
                    if (!rw_q) begin
                        data_r <= in_range ? mem[idx] : 8'h00;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM write at the completing edge; out-of-range writes and reset suppress it.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_DONE) && rw_q && in_range) begin
            mem[idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_xsimbus_responder.sv
// Directed bench for xsimbus_responder: one instance with two wait states and
// a 128-byte RAM, one with zero wait states and a 256-byte RAM, on a shared bus.
module tb_xsimbus_responder;

    localparam logic [4:0] ID2 = 5'd1;
    localparam logic [4:0] ID0 = 5'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic [4:0] sel_id;
    logic [7:0] addr;
    logic       rw;
    logic [7:0] din;

    int checks = 0;
    int errors = 0;

    xsimbus_responder_if #(.ADDR_W(8)) bus2 ();
    xsimbus_responder_if #(.ADDR_W(8)) bus0 ();

    assign bus2.hold_in   = hold;
    assign bus2.sel_id_in = sel_id;
    assign bus2.addr_in   = addr;
    assign bus2.rw_in     = rw;
    assign bus2.data_in   = din;
    assign bus0.hold_in   = hold;
    assign bus0.sel_id_in = sel_id;
    assign bus0.addr_in   = addr;
    assign bus0.rw_in     = rw;
    assign bus0.data_in   = din;

    xsimbus_responder #(.DEV_ID(ID2), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u_w2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    xsimbus_responder #(.DEV_ID(ID0), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input bit z);
        return z ? bus0.ready_out : bus2.ready_out;
    endfunction

    // Drive one transaction, wait (bounded) for ready, then deselect for a cycle.
    // lat = edges from the accepting edge to the edge that raised ready.
    task automatic xact(input bit z, input logic [7:0] a, input bit w, input logic [7:0] d,
                        output int lat, output logic [7:0] dout, output logic err);
        sel_id = z ? ID0 : ID2;
        addr   = a;
        rw     = w;
        din    = d;
        hold   = 1'b1;
        lat    = -1;
        dout   = 8'hxx;
        err    = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (rdy(z)) begin
                lat  = n - 1;
                dout = z ? bus0.data_out : bus2.data_out;
                err  = z ? bus0.err_out : bus2.err_out;
                break;
            end
        end
        hold = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; sel_id = 5'd0; addr = 8'h00; rw = 1'b0; din = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus2.data_out !== 8'h00) begin errors++; $display("FAIL reset_w2_data got %h want 00", bus2.data_out); end
        checks++; if (bus2.ready_out !== 1'b0) begin errors++; $display("FAIL reset_w2_ready got %b want 0", bus2.ready_out); end
        checks++; if (bus2.err_out !== 1'b0) begin errors++; $display("FAIL reset_w2_err got %b want 0", bus2.err_out); end
        checks++; if (bus2.busy_out !== 1'b0) begin errors++; $display("FAIL reset_w2_busy got %b want 0", bus2.busy_out); end
        checks++; if ({bus0.data_out, bus0.ready_out, bus0.err_out, bus0.busy_out} !== 11'd0) begin
            errors++; $display("FAIL reset_w0_outs got %h/%b%b%b want 00/000", bus0.data_out, bus0.ready_out, bus0.err_out, bus0.busy_out);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [7:0] d; logic e;
        xact(1'b0, 8'h10, 1'b1, 8'hA5, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
        checks++; if (bus2.ready_out !== 1'b0) begin errors++; $display("FAIL wr_pulse_width got %b want 0", bus2.ready_out); end
        xact(1'b0, 8'h10, 1'b0, 8'h00, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rd_data got %h want a5", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", e); end
        checks++; if (bus2.data_out !== 8'hA5) begin errors++; $display("FAIL rd_data_hold got %h want a5", bus2.data_out); end
    endtask

    task automatic test_zero_wait();
        int lat; logic [7:0] d; logic e;
        xact(1'b1, 8'h00, 1'b1, 8'h3C, lat, d, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zw_wr_latency got %0d want 1", lat); end
        xact(1'b1, 8'h00, 1'b0, 8'h00, lat, d, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zw_rd_latency got %0d want 1", lat); end
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL zw_rd_data got %h want 3c", d); end
    endtask

    task automatic test_held_request();
        int pulses = 0; int busy_cnt = 0; int lat; logic [7:0] d; logic e;
        sel_id = ID2; addr = 8'h40; rw = 1'b1; din = 8'h5A; hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus2.busy_out) busy_cnt++;
            if (bus2.ready_out) begin
                pulses++;
                din = 8'hC3;
            end
        end
        hold = 1'b0;
        tick();
        checks++; if (pulses !== 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses); end
        checks++; if (busy_cnt !== 3) begin errors++; $display("FAIL held_busy_cycles got %0d want 3", busy_cnt); end
        xact(1'b0, 8'h40, 1'b0, 8'h00, lat, d, e);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL held_mem got %h want 5a", d); end
    endtask

    task automatic test_foreign_and_range();
        int act = 0; int lat; logic [7:0] d; logic e;
        sel_id = ID2 + 5'd1; addr = 8'h10; rw = 1'b0; hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus2.busy_out || bus2.ready_out || bus0.busy_out || bus0.ready_out) act++;
        end
        hold = 1'b0;
        tick();
        checks++; if (act !== 0) begin errors++; $display("FAIL foreign_activity got %0d want 0", act); end
        xact(1'b0, 8'h90, 1'b0, 8'h00, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_latency got %0d want 3", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b want 1", e); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL oor_rd_data got %h want 00", d); end
        checks++; if (bus2.err_out !== 1'b0) begin errors++; $display("FAIL oor_err_width got %b want 0", bus2.err_out); end
        xact(1'b0, 8'h90, 1'b1, 8'hFF, lat, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b want 1", e); end
        xact(1'b0, 8'h10, 1'b0, 8'h00, lat, d, e);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL oor_no_alias got %h want a5", d); end
    endtask

    task automatic test_bus_change();
        int lat = -1; logic [7:0] d; logic e;
        xact(1'b0, 8'h21, 1'b1, 8'h00, lat, d, e);
        sel_id = ID2; addr = 8'h20; rw = 1'b1; din = 8'h77; hold = 1'b1;
        tick();
        hold = 1'b0; addr = 8'h21; din = 8'h99; rw = 1'b0; sel_id = ID0;
        lat = -1;
        for (int n = 2; n <= 20; n++) begin
            tick();
            if (bus2.ready_out) begin
                lat = n - 1;
                break;
            end
        end
        tick();
        checks++; if (lat !== 3) begin errors++; $display("FAIL chg_latency got %0d want 3", lat); end
        xact(1'b0, 8'h20, 1'b0, 8'h00, lat, d, e);
        checks++; if (d !== 8'h77) begin errors++; $display("FAIL chg_target got %h want 77", d); end
        xact(1'b0, 8'h21, 1'b0, 8'h00, lat, d, e);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL chg_other got %h want 00", d); end
    endtask

    task automatic test_reset_mid_wait();
        int act = 0; int lat; logic [7:0] d; logic e;
        xact(1'b0, 8'h30, 1'b1, 8'h11, lat, d, e);
        sel_id = ID2; addr = 8'h30; rw = 1'b1; din = 8'hEE; hold = 1'b1;
        tick();
        checks++; if (bus2.busy_out !== 1'b1) begin errors++; $display("FAIL rstw_busy_before got %b want 1", bus2.busy_out); end
        rst = 1'b1; hold = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if ({bus2.data_out, bus2.ready_out, bus2.err_out, bus2.busy_out} !== 11'd0) begin
            errors++; $display("FAIL rstw_outs got %h/%b%b%b want 00/000", bus2.data_out, bus2.ready_out, bus2.err_out, bus2.busy_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus2.ready_out || bus2.busy_out) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL rstw_no_completion got %0d want 0", act); end
        xact(1'b0, 8'h30, 1'b0, 8'h00, lat, d, e);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL rstw_mem got %h want 11", d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_held_request();
        test_foreign_and_range();
        test_bus_change();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
